vga_pixel_pipe: RTL

- Sits directly downstream of the VGA timing generator.
- Consumes its column, row, HSync, VSync and display-enable outputs.
- Reads a single-port on-chip framebuffer and drives the RGB pins, with sync delayed to stay pixel-aligned.
- A valid/ready write port lets the host fill the framebuffer; writes are committed only during blanking.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pixel_pipe_if.sv | 38 +++
 rtl/vga_frame_ram.sv | 25 ++
 rtl/vga_pixel_pipe.sv | 89 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel pipeline.
// Build option: VGA_TEST_PATTERN_EN selects colour bars instead of framebuffer data.
package vga_pkg;

  localparam int PIXEL_W = 3;
  localparam logic [PIXEL_W-1:0] BLACK = 3'b000;
  localparam logic [PIXEL_W-1:0] WHITE = 3'b111;

  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  localparam int X_W    = 8;
  localparam int Y_W    = 8;
  localparam int ADDR_W = X_W + Y_W;

  localparam int PIPE_LAT = 2;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display;
  } sync_t;

  function automatic int addr_w(input int xw, input int yw);
    return xw + yw;
  endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Timing-generator inputs, host write port and VGA pins of the pixel pipe.
// master = timing generator / host / pins side, slave = pixel pipe.
interface vga_pixel_pipe_if #(
  parameter int XWidth = 8,
  parameter int YWidth = 8
);
  import vga_pkg::*;

  logic [XWidth-1:0]        col;
  logic [YWidth-1:0]        row;
  logic                     hsync;
  logic                     vsync;
  logic                     display;
  logic                     wr_valid;
  logic [XWidth+YWidth-1:0] wr_addr;
  pixel_t                   wr_data;
  logic                     wr_ready;
  logic                     red;
  logic                     green;
  logic                     blue;
  logic                     vga_hsync;
  logic                     vga_vsync;

  modport master (
    output col, row, hsync, vsync, display,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    input  red, green, blue, vga_hsync, vga_vsync
  );

  modport slave (
    input  col, row, hsync, vsync, display,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    output red, green, blue, vga_hsync, vga_vsync
  );

endinterface

// File: rtl/vga_frame_ram.sv
// Single-port framebuffer, synchronous read; a write cycle does not
// update the read data.
module vga_frame_ram
  import vga_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  pixel_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vga_pixel_pipe.sv
// Framebuffer-to-pins pixel pipe, 2-cycle latency, blanking-only writes.
// Build option: VGA_TEST_PATTERN_EN shows 8 vertical colour bars.
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int XWidth = 8,
  parameter int YWidth = 8
) (
  input logic             clk,
  input logic             rst,
  vga_pixel_pipe_if.slave bus
);

  localparam int AW = addr_w(XWidth, YWidth);

  logic          full;
  logic [AW-1:0] hold_addr;
  pixel_t        hold_data;
  logic          commit;
  logic [AW-1:0] ram_addr;
  pixel_t        rdata;
  pixel_t        src;
  pixel_t        rgb;
  sync_t         s1;
  sync_t         s2;

  // Reads own the port in the visible area; writes use blanking only.
  assign commit   = full && !bus.display;
  assign ram_addr = commit ? hold_addr : {bus.row, bus.col};

  vga_frame_ram #(
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .addr  (ram_addr),
    .wdata (hold_data),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (bus.wr_valid && !full) begin
      full <= 1'b1;
    end else if (commit) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_valid && !full) begin
      hold_addr <= bus.wr_addr;
      hold_data <= bus.wr_data;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  pixel_t bar1;

  always_ff @(posedge clk) begin
    bar1 <= bus.col[XWidth-1:XWidth-3];
  end

  assign src = bar1;
`else
  assign src = rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '{SYNC_IDLE, SYNC_IDLE, 1'b0};
      s2  <= '{SYNC_IDLE, SYNC_IDLE, 1'b0};
      rgb <= BLACK;
    end else begin
      s1  <= '{bus.hsync, bus.vsync, bus.display};
      s2  <= s1;
      rgb <= s1.display ? src : BLACK;
    end
  end

  assign bus.wr_ready  = !full;
  assign bus.red       = rgb[2];
  assign bus.green     = rgb[1];
  assign bus.blue      = rgb[0];
  assign bus.vga_hsync = s2.hsync;
  assign bus.vga_vsync = s2.vsync;

endmodule
